// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program counter unit.
package pc_pkg;

    localparam int PC_ADDR_W_DEF    = 8;
    localparam int PC_STEP_DEF      = 1;
    localparam int PC_RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        PC_SEL_HOLD,
        PC_SEL_INC,
        PC_SEL_TGT,
        PC_SEL_RET
    } pc_sel_t;

endpackage

// File: rtl/program_counter_unit_if.sv
// Control/status bundle between the decode/control unit (master) and the PC unit (slave).
interface program_counter_unit_if import pc_pkg::*; #(
    parameter int ADDR_W = PC_ADDR_W_DEF
);
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_err;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret,
        input  pc, pc_next, ras_full, ras_empty, ras_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret,
        output pc, pc_next, ras_full, ras_empty, ras_err
    );

endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry,
// a pop returns the most recent entry.
module return_addr_stack import pc_pkg::*; #(
    parameter int ADDR_W    = PC_ADDR_W_DEF,
    parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_up;
    logic [CNT_W-1:0]  count;
    logic              do_pop;
    logic              do_push;

    // Depth is a power of two, so the pointer wraps around the ring on its own.
    assign top_up  = top + PTR_W'(1);
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop;
    assign top_addr = mem[top];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top   <= '0;
            count <= '0;
        end else if (do_pop) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
        end else if (do_push) begin
            top <= top_up;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // NOTE: entry storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[top_up] <= push_addr;
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch program counter with stall, redirect and call/return control.
// Define PC_RAS_EN to build the return-address stack; otherwise call is a plain redirect.
module program_counter_unit import pc_pkg::*; #(
    parameter int                ADDR_W     = PC_ADDR_W_DEF,
    parameter int                STEP       = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                RAS_DEPTH  = PC_RAS_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    program_counter_unit_if.slave  bus
);
    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic              call_tgt;

    assign pc_inc = pc_q + ADDR_W'(STEP);

`ifdef PC_RAS_EN
    logic push;
    logic err_nxt;
    logic err_q;

    // A call alongside a ret is dropped: ret owns the stack that cycle.
    assign call_tgt = bus.call && !bus.ret;
    assign push     = !bus.stall && call_tgt;
    assign err_nxt  = !bus.stall &&
                      ((bus.ret && ras_empty) || (bus.call && bus.ret) || (call_tgt && ras_full));

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (sel == PC_SEL_RET),
        .push_addr (pc_inc),
        .top_addr  (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end

    assign bus.ras_err = err_q;
`else
    // With no stack, ret always sees an empty stack and falls through.
    assign call_tgt    = bus.call;
    assign ras_top     = '0;
    assign ras_full    = 1'b0;
    assign ras_empty   = 1'b1;
    assign bus.ras_err = 1'b0;
`endif

    // NOTE: every branch assigns sel after the default, so no latch is inferred.
    always_comb begin
        sel = PC_SEL_INC;
        if (bus.stall) begin
            sel = PC_SEL_HOLD;
        end else if (bus.ret && !ras_empty) begin
            sel = PC_SEL_RET;
        end else if (call_tgt || bus.redirect_valid) begin
            sel = PC_SEL_TGT;
        end
    end

    always_comb begin
        pc_nxt = pc_inc;
        case (sel)
            PC_SEL_HOLD: pc_nxt = pc_q;
            PC_SEL_RET:  pc_nxt = ras_top;
            PC_SEL_TGT:  pc_nxt = bus.redirect_target;
            default:     pc_nxt = pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_next   = pc_nxt;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench: dut_a (RESET_ADDR 8'h10, STEP 4) for reset/advance, dut_b (STEP 1) for control vectors.
module tb_program_counter_unit;

    typedef struct {
        string      name;
        logic       stall;
        logic       redir;
        logic       call;
        logic       ret;
        logic [7:0] tgt;
        logic [7:0] exp_next;
        logic [7:0] exp_pc;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    program_counter_unit_if #(.ADDR_W(8)) bus_a ();
    program_counter_unit_if #(.ADDR_W(8)) bus_b ();

    program_counter_unit #(
        .ADDR_W(8), .STEP(4), .RESET_ADDR(8'h10), .RAS_DEPTH(4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    program_counter_unit #(
        .ADDR_W(8), .STEP(1), .RESET_ADDR(8'h00), .RAS_DEPTH(4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic stall, input logic redir,
                                input logic call, input logic ret, input logic [7:0] tgt,
                                input logic [7:0] exp_next, input logic [7:0] exp_pc,
                                input logic exp_empty, input logic exp_full, input logic exp_err);
        vec_t v;
        v.name = name; v.stall = stall; v.redir = redir; v.call = call; v.ret = ret; v.tgt = tgt;
        v.exp_next = exp_next; v.exp_pc = exp_pc;
        v.exp_empty = exp_empty; v.exp_full = exp_full; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus_b.stall           = v.stall;
        bus_b.redirect_valid  = v.redir;
        bus_b.call            = v.call;
        bus_b.ret             = v.ret;
        bus_b.redirect_target = v.tgt;
        #1;
        check({v.name, "/pc_next"}, 32'(bus_b.pc_next), 32'(v.exp_next));
        @(posedge clk);
        #1;
        check({v.name, "/pc"},    32'(bus_b.pc),        32'(v.exp_pc));
        check({v.name, "/empty"}, 32'(bus_b.ras_empty), 32'(v.exp_empty));
        check({v.name, "/full"},  32'(bus_b.ras_full),  32'(v.exp_full));
        check({v.name, "/err"},   32'(bus_b.ras_err),   32'(v.exp_err));
    endtask

    initial begin
        vec_t tbl[$];

        // name, stall, redir, call, ret, tgt, exp_next, exp_pc, empty, full, err
        tbl.push_back(mk("redir_fe",  0, 1, 0, 0, 8'hFE, 8'hFE, 8'hFE, 1, 0, 0));
        tbl.push_back(mk("inc_ff",    0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF, 1, 0, 0));
        tbl.push_back(mk("wrap_00",   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk("stall_1",   1, 1, 0, 0, 8'h30, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk("stall_2",   1, 1, 0, 0, 8'h30, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk("redir_30",  0, 1, 0, 0, 8'h30, 8'h30, 8'h30, 1, 0, 0));
        tbl.push_back(mk("stall_ctl", 1, 0, 1, 1, 8'h55, 8'h30, 8'h30, 1, 0, 0));
`ifdef PC_RAS_EN
        tbl.push_back(mk("redir_05",  0, 1, 0, 0, 8'h05, 8'h05, 8'h05, 1, 0, 0));
        tbl.push_back(mk("call_40",   0, 0, 1, 0, 8'h40, 8'h40, 8'h40, 0, 0, 0));
        tbl.push_back(mk("ret_06",    0, 0, 0, 1, 8'h00, 8'h06, 8'h06, 1, 0, 0));
        tbl.push_back(mk("redir_10",  0, 1, 0, 0, 8'h10, 8'h10, 8'h10, 1, 0, 0));
        tbl.push_back(mk("nest_1",    0, 0, 1, 0, 8'h20, 8'h20, 8'h20, 0, 0, 0));
        tbl.push_back(mk("nest_2",    0, 0, 1, 0, 8'h30, 8'h30, 8'h30, 0, 0, 0));
        tbl.push_back(mk("nest_3",    0, 0, 1, 0, 8'h40, 8'h40, 8'h40, 0, 0, 0));
        tbl.push_back(mk("nest_4",    0, 0, 1, 0, 8'h50, 8'h50, 8'h50, 0, 1, 0));
        tbl.push_back(mk("overflow",  0, 0, 1, 0, 8'h60, 8'h60, 8'h60, 0, 1, 1));
        tbl.push_back(mk("pop_51",    0, 0, 0, 1, 8'h00, 8'h51, 8'h51, 0, 0, 0));
        tbl.push_back(mk("pop_41",    0, 0, 0, 1, 8'h00, 8'h41, 8'h41, 0, 0, 0));
        tbl.push_back(mk("pop_31",    0, 0, 0, 1, 8'h00, 8'h31, 8'h31, 0, 0, 0));
        tbl.push_back(mk("pop_21",    0, 0, 0, 1, 8'h00, 8'h21, 8'h21, 1, 0, 0));
        tbl.push_back(mk("underflow", 0, 1, 0, 1, 8'h80, 8'h80, 8'h80, 1, 0, 1));
        tbl.push_back(mk("redir_21",  0, 1, 0, 0, 8'h21, 8'h21, 8'h21, 1, 0, 0));
        tbl.push_back(mk("call_70",   0, 0, 1, 0, 8'h70, 8'h70, 8'h70, 0, 0, 0));
        tbl.push_back(mk("stall_ret", 1, 0, 0, 1, 8'h00, 8'h70, 8'h70, 0, 0, 0));
        tbl.push_back(mk("conflict",  0, 0, 1, 1, 8'h99, 8'h22, 8'h22, 1, 0, 1));
        tbl.push_back(mk("idle_23",   0, 0, 0, 0, 8'h00, 8'h23, 8'h23, 1, 0, 0));
`else
        tbl.push_back(mk("call_40",   0, 0, 1, 0, 8'h40, 8'h40, 8'h40, 1, 0, 0));
        tbl.push_back(mk("ret_41",    0, 0, 0, 1, 8'h00, 8'h41, 8'h41, 1, 0, 0));
        tbl.push_back(mk("ret_redir", 0, 1, 0, 1, 8'h80, 8'h80, 8'h80, 1, 0, 0));
        tbl.push_back(mk("call_ret",  0, 0, 1, 1, 8'h22, 8'h22, 8'h22, 1, 0, 0));
        tbl.push_back(mk("idle_23",   0, 0, 0, 0, 8'h00, 8'h23, 8'h23, 1, 0, 0));
`endif

        reset = 1'b1;
        bus_a.stall = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.call = 1'b0; bus_a.ret = 1'b0;
        bus_a.redirect_target = 8'h00;
        bus_b.stall = 1'b0; bus_b.redirect_valid = 1'b0; bus_b.call = 1'b0; bus_b.ret = 1'b0;
        bus_b.redirect_target = 8'h00;

        // Reset values before any clock edge.
        #3;
        check("rst_pc_a",    32'(bus_a.pc),        32'h10);
        check("rst_pc_b",    32'(bus_b.pc),        32'h00);
        check("rst_empty_b", 32'(bus_b.ras_empty), 32'h1);
        check("rst_full_b",  32'(bus_b.ras_full),  32'h0);
        check("rst_err_b",   32'(bus_b.ras_err),   32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("adv_pc_a_0",   32'(bus_a.pc),      32'h10);
        check("adv_next_a_0", 32'(bus_a.pc_next), 32'h14);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("adv_pc_a_%0d", i), 32'(bus_a.pc), 32'(8'h10 + 8'(4 * i)));
        end

        // Mid-cycle reset must act without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("midrst_pc_a",    32'(bus_a.pc),        32'h10);
        check("midrst_pc_b",    32'(bus_b.pc),        32'h00);
        check("midrst_empty_b", 32'(bus_b.ras_empty), 32'h1);
        check("midrst_err_b",   32'(bus_b.ras_err),   32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
